fpmul_pipe: RTL and testbench
=============================

FPMUL_PIPE -- requirements
Module: fpmul_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 Parameter MAN_W, default 23, stored mantissa field width (range 3..52).
REQ-003 Derived width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block accepts operands this cycle.
REQ-008 opa, opb  in  W  IEEE-754-format operands.
REQ-009 rmode  in  2  rounding mode, sampled with operands: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out  out  W  product.
REQ-013 flags  out  6  {inf, nan, ine, overflow, underflow, zero}, aligned with out.

Function
REQ-014 Transfer in occurs when in_valid&in_ready; transfer out occurs when out_valid&out_ready.
REQ-015 Pipeline has 3 stages: S1 unpack/classify/exponent sum, S2 mantissa product, S3 normalise/round/pack.
REQ-016 Latency is exactly 3 cycles from input transfer to out_valid when out_ready stays high; throughput is 1 per cycle.
REQ-017 Stall is global: advance = !out_valid | out_ready; in_ready = advance; no stage changes while !advance.
REQ-018 Bubbles propagate; a stage valid bit clears when advance and the upstream stage is empty.
REQ-019 out, flags hold stable while out_valid&!out_ready.
REQ-020 Subnormal inputs are flushed to signed zero before use; ine is not set by flushing.
REQ-021 Sign of every non-NaN result = sign(opa) XOR sign(opb).
REQ-022 Mantissa product: (MAN_W+1)x(MAN_W+1) unsigned, 2*MAN_W+2 bits; normalise by at most 1-bit right shift with exponent increment.
REQ-023 Rounding uses guard bit and sticky (OR of all lower bits) per rmode; mantissa carry-out on round increments exponent.
REQ-024 ine = 1 when guard|sticky, or when overflow or underflow is set.
REQ-025 Overflow (biased exponent >= 2^EXP_W-1 after rounding): RNE gives inf; RTZ gives max finite; +inf mode gives +inf if positive, else -max; -inf mode gives -inf if negative, else +max; overflow=1; inf=1 only if result is inf.
REQ-026 Underflow (biased exponent <= 0 after rounding): result is signed zero, underflow=1, ine=1, zero=1.
REQ-027 NaN input, or inf x zero: out = canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), nan=1, all other flags 0.
REQ-028 inf x finite-nonzero or inf x inf: signed inf, inf=1, overflow=0, ine=0.
REQ-029 Any zero (including flushed subnormal) x finite: signed zero, zero=1.
REQ-030 Exponent arithmetic uses EXP_W+2-bit signed intermediates so no wrap-around occurs for any operand pair.

Reset
REQ-031 While rst is high, all stage valid bits and out_valid = 0, out = 0, flags = 0; in_ready = 1 after release.
REQ-032 Reset mid-operation discards all in-flight operations; no result appears for them after release.
REQ-033 Datapath registers other than valid bits, out and flags have no reset.

Structure
REQ-034 Shared package holds the rmode encodings, the flag bit indices, and a function that builds the canonical qNaN for given EXP_W/MAN_W.
REQ-035 The S3 normalise/round/pack logic is one combinational sub-module, fpmul_round, parametrised by EXP_W and MAN_W.
REQ-036 The mantissa multiply is inferred with "*" and has one register stage.

Verification (EXP_W=8, MAN_W=23)
REQ-037 3F800000 x 3F800000, RNE, out_ready=1: out=3F800000 at cycle 3, flags=0; then 40000000 x 40400000: out=40C00000.
REQ-038 3F800001 x 3F800001: RNE gives 3F800002, +inf mode gives 3F800003, RTZ gives 3F800002; ine=1 in all three.
REQ-039 7F7FFFFF x 40000000: RNE gives 7F800000 with overflow,ine,inf=1; RTZ gives 7F7FFFFF with overflow,ine=1; FF7FFFFF x 40000000 in +inf mode gives FF7FFFFF.
REQ-040 7F800000 x 00000000 gives 7FC00000 with nan=1; 00800000 x 3F000000 gives 00000000 with underflow,ine,zero=1; 80000001 x 3F800000 gives 80000000 with zero=1.
REQ-041 Back-to-back 8 operations with out_ready toggling randomly, plus rst asserted mid-stream: results are in order, none lost or duplicated, out is stable during stalls, and nothing appears after reset.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// rounding-mode encodings, flag bit positions, operand class record and
// the canonical quiet-NaN builder.
package fpmul_pkg;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_POS = 2'b10,
      RM_NEG = 2'b11
   } rmode_e;

   localparam int FLAG_W    = 6;
   localparam int FLAG_ZERO = 0;
   localparam int FLAG_UNF  = 1;
   localparam int FLAG_OVF  = 2;
   localparam int FLAG_INE  = 3;
   localparam int FLAG_NAN  = 4;
   localparam int FLAG_INF  = 5;

   // Special-case classification of the operand pair, decided in S1.
   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } opclass_t;

   // Canonical qNaN: sign 0, exponent all ones, only the mantissa MSB set.
   // Built at 64 bits (widest legal format); callers size-cast to their width.
   function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << man_w;
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/fpmul_round.sv
// Combinational normalise / round / pack stage of the multiplier.
// Takes the raw mantissa product, the unbiased-corrected exponent sum and the
// special-case class, and produces the packed result and its flags.
module fpmul_round
   import fpmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W  = 1 + EXP_W + MAN_W,
   localparam int PW = 2 * MAN_W + 2,
   localparam int EW = EXP_W + 2
) (
   input  logic                  sign,
   input  logic signed [EW-1:0]  exp_sum,
   input  logic [PW-1:0]         prod,
   input  rmode_e                rmode,
   input  opclass_t              cls,
   output logic [W-1:0]          res,
   output logic [FLAG_W-1:0]     flags
);

   localparam logic [EXP_W-1:0]      EXP_ONES = '1;
   localparam logic [EXP_W-1:0]      EXP_MAX  = EXP_ONES - 1'b1;
   localparam logic signed [EW-1:0]  EXP_OVF  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0]  EXP_ZERO = '0;
   localparam logic [W-1:0]          QNAN     = W'(canon_qnan(EXP_W, MAN_W));

   logic [PW-2:0]          norm;
   logic [MAN_W-1:0]       mant;
   logic                   guard;
   logic                   sticky;
   logic                   inc;
   logic                   to_inf;
   logic [MAN_W:0]         mant_r;
   logic signed [EW-1:0]   exp_n;
   logic signed [EW-1:0]   exp_r;
   logic                   ovf;
   logic                   unf;

   // Normalise (product lies in [1,4)), round per mode, then pick the
   // special-case, overflow, underflow or ordinary result.
   always_comb begin
      norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      mant   = norm[PW-2:MAN_W+1];
      guard  = norm[MAN_W];
      sticky = |norm[MAN_W-1:0];
      exp_n  = exp_sum + $signed({{(EW-1){1'b0}}, prod[PW-1]});

      case (rmode)
         RM_RNE:  begin inc = guard & (sticky | mant[0]); to_inf = 1'b1;  end
         RM_POS:  begin inc = ~sign & (guard | sticky);   to_inf = ~sign; end
         RM_NEG:  begin inc = sign & (guard | sticky);    to_inf = sign;  end
         default: begin inc = 1'b0;                       to_inf = 1'b0;  end
      endcase

      mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
      exp_r  = exp_n + $signed({{(EW-1){1'b0}}, mant_r[MAN_W]});
      ovf    = (exp_r >= EXP_OVF);
      unf    = (exp_r <= EXP_ZERO);

      res   = '0;
      flags = '0;
      if (cls.nan) begin
         res             = QNAN;
         flags[FLAG_NAN] = 1'b1;
      end else if (cls.inf) begin
         res             = {sign, EXP_ONES, {MAN_W{1'b0}}};
         flags[FLAG_INF] = 1'b1;
      end else if (cls.zero) begin
         res              = {sign, {(W-1){1'b0}}};
         flags[FLAG_ZERO] = 1'b1;
      end else if (ovf) begin
         flags[FLAG_OVF] = 1'b1;
         flags[FLAG_INE] = 1'b1;
         if (to_inf) begin
            res             = {sign, EXP_ONES, {MAN_W{1'b0}}};
            flags[FLAG_INF] = 1'b1;
         end else begin
            res = {sign, EXP_MAX, {MAN_W{1'b1}}};
         end
      end else if (unf) begin
         res              = {sign, {(W-1){1'b0}}};
         flags[FLAG_UNF]  = 1'b1;
         flags[FLAG_INE]  = 1'b1;
         flags[FLAG_ZERO] = 1'b1;
      end else begin
         res             = {sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
         flags[FLAG_INE] = guard | sticky;
      end
   end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined IEEE-754-format multiplier with valid/ready handshake.
// S1 unpacks, classifies and sums exponents; S2 registers the mantissa
// product; S3 normalises, rounds and packs into the output register.
// A single global advance signal stalls every stage at once.
module fpmul_pipe
   import fpmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       opa,
   input  logic [W-1:0]       opb,
   input  logic [1:0]         rmode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out,
   output logic [FLAG_W-1:0]  flags
);

   localparam int EW = EXP_W + 2;
   localparam int PW = 2 * MAN_W + 2;
   localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

   logic                  advance;
   logic                  sign_a, sign_b;
   logic [EXP_W-1:0]      exp_a, exp_b;
   logic [MAN_W-1:0]      man_a, man_b;
   logic                  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   opclass_t              cls_in;
   logic signed [EW-1:0]  exp_sum_in;

   logic                  s1_valid;
   logic                  s1_sign;
   logic signed [EW-1:0]  s1_exp;
   logic [MAN_W:0]        s1_ma, s1_mb;
   rmode_e                s1_rmode;
   opclass_t              s1_cls;

   logic                  s2_valid;
   logic                  s2_sign;
   logic signed [EW-1:0]  s2_exp;
   logic [PW-1:0]         s2_prod;
   rmode_e                s2_rmode;
   opclass_t              s2_cls;

   logic [W-1:0]          res;
   logic [FLAG_W-1:0]     res_flags;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Unpack operands and classify; subnormals count as zero (flush).
   always_comb begin
      {sign_a, exp_a, man_a} = opa;
      {sign_b, exp_b, man_b} = opb;
      nan_a  = (&exp_a) & (|man_a);
      nan_b  = (&exp_b) & (|man_b);
      inf_a  = (&exp_a) & ~(|man_a);
      inf_b  = (&exp_b) & ~(|man_b);
      zero_a = ~(|exp_a);
      zero_b = ~(|exp_b);
      cls_in.nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
      cls_in.inf  = inf_a | inf_b;
      cls_in.zero = zero_a | zero_b;
      exp_sum_in  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
   end

   // Valid bits and the output register: cleared by reset, frozen on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out       <= '0;
         flags     <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            out   <= res;
            flags <= res_flags;
         end
      end
   end

   // Unreset datapath registers for S1 and S2, including the product stage.
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign  <= sign_a ^ sign_b;
         s1_exp   <= exp_sum_in;
         s1_ma    <= {1'b1, man_a};
         s1_mb    <= {1'b1, man_b};
         s1_rmode <= rmode_e'(rmode);
         s1_cls   <= cls_in;
         s2_sign  <= s1_sign;
         s2_exp   <= s1_exp;
         s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
         s2_rmode <= s1_rmode;
         s2_cls   <= s1_cls;
      end
   end

   fpmul_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign    (s2_sign),
      .exp_sum (s2_exp),
      .prod    (s2_prod),
      .rmode   (s2_rmode),
      .cls     (s2_cls),
      .res     (res),
      .flags   (res_flags)
   );

endmodule

// File: tb/tb_fpmul_pipe.sv
// Directed scoreboard bench for fpmul_pipe in single-precision format.
module tb_fpmul_pipe;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 32;

   typedef struct {
      int          id;
      logic [31:0] o;
      logic [5:0]  f;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  opa = '0;
   logic [W-1:0]  opb = '0;
   logic [1:0]    rmode = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out;
   logic [5:0]    flags;

   int            total = 0;
   int            bad = 0;
   int            op_count = 0;
   bit            random_mode = 1'b0;
   exp_t          exp_q[$];
   bit            hold_pending = 1'b0;
   logic [31:0]   held_out;
   logic [5:0]    held_flags;

   fpmul_pipe #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opa       (opa),
      .opb       (opb),
      .rmode     (rmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Consumer: ready held high or randomised each cycle just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard check each falling edge while out of reset.
   always @(negedge clk) begin
      if (rst === 1'b1) hold_pending = 1'b0;
      else checkOutput();
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog time limit reached with %0d results outstanding", exp_q.size());
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput();
      exp_t e;
      if (hold_pending) begin
         total++;
         assert (out_valid === 1'b1 && out === held_out && flags === held_flags)
         else begin
            bad++;
            $error("[TB] FAIL stall_hold valid=%b out=%h flags=%b required valid=1 out=%h flags=%b",
                   out_valid, out, flags, held_out, held_flags);
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         assert (exp_q.size() > 0)
         else begin
            bad++;
            $error("[TB] FAIL unexpected_result out=%h flags=%b required no result", out, flags);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (out === e.o)
            else begin
               bad++;
               $error("[TB] FAIL op%0d_out got=%h required=%h", e.id, out, e.o);
            end
            total++;
            assert (flags === e.f)
            else begin
               bad++;
               $error("[TB] FAIL op%0d_flags got=%b required=%b", e.id, flags, e.f);
            end
         end
      end
      hold_pending = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_out     = out;
      held_flags   = flags;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                                input logic [31:0] eo, input logic [5:0] ef);
      int   wait_cycles;
      exp_t item;
      @(negedge clk);
      opa      = a;
      opb      = b;
      rmode    = rm;
      in_valid = 1'b1;
      wait_cycles = 0;
      while (in_ready !== 1'b1 && wait_cycles < 200) begin
         @(negedge clk);
         wait_cycles++;
      end
      total++;
      assert (in_ready === 1'b1)
      else begin
         bad++;
         $error("[TB] FAIL accept_op%0d in_ready=%b required=1 within 200 cycles", op_count, in_ready);
      end
      item.id = op_count;
      item.o  = eo;
      item.f  = ef;
      op_count++;
      if (in_ready === 1'b1) exp_q.push_back(item);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drainResults();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (exp_q.size() == 0)
      else begin
         bad++;
         $error("[TB] FAIL drain outstanding=%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      assert (out_valid === 1'b0 && out === 32'h0 && flags === 6'h0)
      else begin
         bad++;
         $error("[TB] FAIL reset_state valid=%b out=%h flags=%b required 0/00000000/000000",
                out_valid, out, flags);
      end
      rst = 1'b0;
      #1;
      total++;
      assert (in_ready === 1'b1)
      else begin
         bad++;
         $error("[TB] FAIL ready_after_reset got=%b required=1", in_ready);
      end

      // Latency: transfer edge, then result visible after the third edge.
      $display("[TB] latency check");
      applyStimulus(32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000, 6'b000000);
      total++;
      assert (out_valid === 1'b0)
      else begin bad++; $error("[TB] FAIL latency_c1 valid=%b required=0", out_valid); end
      @(posedge clk); #1;
      total++;
      assert (out_valid === 1'b0)
      else begin bad++; $error("[TB] FAIL latency_c2 valid=%b required=0", out_valid); end
      @(posedge clk); #1;
      total++;
      assert (out_valid === 1'b1 && out === 32'h3F800000 && flags === 6'b000000)
      else begin
         bad++;
         $error("[TB] FAIL latency_c3 valid=%b out=%h flags=%b required 1/3F800000/000000",
                out_valid, out, flags);
      end
      applyStimulus(32'h40000000, 32'h40400000, 2'b00, 32'h40C00000, 6'b000000);
      drainResults();

      // Directed cases, back to back, with the consumer stalling randomly.
      $display("[TB] directed stream with random backpressure");
      random_mode = 1'b1;
      applyStimulus(32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 6'b001000);
      applyStimulus(32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 6'b001000);
      applyStimulus(32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 6'b001000);
      applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 6'b101100);
      applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF, 6'b001100);
      applyStimulus(32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF7FFFFF, 6'b001100);
      applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F7FFFFF, 6'b001100);
      applyStimulus(32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF800000, 6'b101100);
      applyStimulus(32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 6'b010000);
      applyStimulus(32'h00000000, 32'hFF800000, 2'b00, 32'h7FC00000, 6'b010000);
      applyStimulus(32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 6'b010000);
      applyStimulus(32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 6'b001011);
      applyStimulus(32'h80000001, 32'h3F800000, 2'b00, 32'h80000000, 6'b000001);
      applyStimulus(32'h3F800000, 32'hBF800000, 2'b00, 32'hBF800000, 6'b000000);
      applyStimulus(32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 6'b100000);
      applyStimulus(32'h7F800000, 32'hFF800000, 2'b00, 32'hFF800000, 6'b100000);
      applyStimulus(32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 6'b001000);
      applyStimulus(32'hBF800001, 32'h3F800001, 2'b10, 32'hBF800002, 6'b001000);
      applyStimulus(32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, 6'b001000);
      applyStimulus(32'h3F800003, 32'h3FC00000, 2'b00, 32'h3FC00004, 6'b001000);
      applyStimulus(32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000, 6'b000000);
      drainResults();

      // Reset in the middle of a stream: in-flight work must vanish.
      $display("[TB] reset mid-stream");
      applyStimulus(32'h40000000, 32'h40000000, 2'b00, 32'h40800000, 6'b000000);
      applyStimulus(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 6'b000000);
      applyStimulus(32'h3F800000, 32'h40400000, 2'b00, 32'h40400000, 6'b000000);
      applyStimulus(32'hC0000000, 32'h40000000, 2'b00, 32'hC0800000, 6'b000000);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      total++;
      assert (out_valid === 1'b0 && out === 32'h0 && flags === 6'h0)
      else begin
         bad++;
         $error("[TB] FAIL mid_reset_state valid=%b out=%h flags=%b required 0/00000000/000000",
                out_valid, out, flags);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      assert (in_ready === 1'b1)
      else begin
         bad++;
         $error("[TB] FAIL ready_after_mid_reset got=%b required=1", in_ready);
      end
      repeat (12) @(negedge clk);
      total++;
      assert (out_valid === 1'b0)
      else begin
         bad++;
         $error("[TB] FAIL ghost_after_reset valid=%b required=0", out_valid);
      end

      // Pipeline must resume normally after the reset.
      applyStimulus(32'h40000000, 32'h40400000, 2'b00, 32'h40C00000, 6'b000000);
      applyStimulus(32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 6'b001000);
      applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000, 6'b101100);
      applyStimulus(32'h80000001, 32'h3F800000, 2'b00, 32'h80000000, 6'b000001);
      drainResults();
      random_mode = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
